// File: rtl/spi_coeff_loader.sv
// spi_coeff_loader: SPI receiver that loads biquad coefficients and commits them on an audio sample tick.
module spi_coeff_loader #(
    parameter int N_BANDS = 3,
    parameter int N_COEFF = 5,
    parameter int COEFF_W = 16,
    parameter int PAD_W   = 96
) (
    input  logic                               lmmi_clk_i,
    input  logic                               reset_n_i,
    input  logic                               sck,
    input  logic                               sdi,
    input  logic                               cs,
    input  logic                               sample_tick_i,
    output logic [N_BANDS*N_COEFF*COEFF_W-1:0] coeff_o,
    output logic                               update_o,
    output logic                               pending_o,
    output logic                               frame_err_o
);
    localparam int N_SLOT  = N_BANDS * N_COEFF;
    localparam int DATA_W  = N_SLOT * COEFF_W;
    localparam int FRAME_W = PAD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    function automatic logic [DATA_W-1:0] reset_coeff();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int b = 0; b < N_BANDS; b++)
            v[b*N_COEFF*COEFF_W +: COEFF_W] = COEFF_W'(1) << (COEFF_W - 2);
        return v;
    endfunction

    localparam logic [DATA_W-1:0] UNITY = reset_coeff();

    logic [2:0]        sck_q, cs_q;
    logic [1:0]        sdi_q, warm;
    logic              armed, in_frame;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sr, shadow, reordered;
    logic              sck_rise, cs_fall, cs_rise, shift_en, accept, commit;

    // Only a cs fall seen after a genuine idle-high level may open a frame.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign cs_fall  = armed & cs_q[2] & ~cs_q[1];
    assign cs_rise  = in_frame & cs_q[1] & ~cs_q[2];
    assign shift_en = in_frame & ~cs_q[1] & sck_rise;
    assign accept   = cs_rise & (cnt == CNT_FULL);
    assign commit   = sample_tick_i & pending_o;

    for (genvar i = 0; i < N_SLOT; i++) begin : g_map
        assign reordered[i*COEFF_W +: COEFF_W] = sr[(N_SLOT-1-i)*COEFF_W +: COEFF_W];
    end

    always_ff @(posedge lmmi_clk_i) begin
        if (!reset_n_i) begin
            sck_q       <= 3'b000;
            cs_q        <= 3'b111;
            sdi_q       <= 2'b00;
            warm        <= 2'b00;
            armed       <= 1'b0;
            in_frame    <= 1'b0;
            cnt         <= '0;
            sr          <= '0;
            shadow      <= UNITY;
            coeff_o     <= UNITY;
            pending_o   <= 1'b0;
            update_o    <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sck_q       <= {sck_q[1:0], sck};
            cs_q        <= {cs_q[1:0], cs};
            sdi_q       <= {sdi_q[0], sdi};
            warm        <= {warm[0], 1'b1};
            armed       <= armed | (warm[1] & cs_q[1]);
            if (cs_fall) begin
                in_frame <= 1'b1;
                cnt      <= '0;
                sr       <= '0;
            end else if (cs_rise) begin
                in_frame <= 1'b0;
            end else if (shift_en) begin
                sr  <= {sr[DATA_W-2:0], sdi_q[1]};
                cnt <= (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
            end
            if (accept)
                shadow <= reordered;
            if (commit)
                coeff_o <= shadow;
            pending_o   <= accept | (pending_o & ~sample_tick_i);
            update_o    <= commit;
            frame_err_o <= cs_rise & ~accept;
        end
    end
endmodule
